// File: rtl/mips_register_file_if.sv
// Register-file access bus between the decode/writeback stages and the
// register file.
//
// Signals:
//   read_reg_1, read_reg_2  source register indices (bit 0 = MSB)
//   write_reg               destination register index (bit 0 = MSB)
//   write_data              value to commit (bit 0 = MSB)
//   reg_write               commit enable, sampled on the rising clock edge
//   rd1, rd2                combinational read data for the two source ports
//
// Protocol: there is no valid/ready handshake. The reads are always
// available, with zero latency. A write is a one-cycle request: when
// reg_write is high at a rising edge, write_data is committed to write_reg
// on that edge. No acknowledge is returned.
//
// Modports: master = datapath side; slave = register file.

interface mips_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [0:ADDR_W-1] read_reg_1;
  logic [0:ADDR_W-1] read_reg_2;
  logic [0:ADDR_W-1] write_reg;
  logic [0:DATA_W-1] write_data;
  logic              reg_write;
  logic [0:DATA_W-1] rd1;
  logic [0:DATA_W-1] rd2;

  modport master (
    output read_reg_1, read_reg_2, write_reg, write_data, reg_write,
    input  rd1, rd2
  );

  modport slave (
    input  read_reg_1, read_reg_2, write_reg, write_data, reg_write,
    output rd1, rd2
  );
endinterface

// File: rtl/mips_register_file.sv
// 2-read / 1-write general-purpose register file for the CPU datapath.
// The decode stage reads two operands combinationally. The writeback stage
// commits one result per clock.
//
// Parameters:
//   DATA_W    register / data port width
//   ADDR_W    index width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads as zero and drops writes
//             0: register 0 is an ordinary register
//
// Ports:
//   clk   rising-edge clock for writes
//   rst   asynchronous active-low reset; clears every register
//   bus   mips_register_file_if.slave (read indices, write request, rd1/rd2)
//
// Reads are not bypassed. Reading the register being written in the same
// cycle returns the old contents. The new value becomes visible right after
// the commit edge.

module mips_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_register_file_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic write_hits_zero;
  logic do_write;

  // With ZERO_REG set, a write to index 0 is dropped here, so register 0
  // holds its reset value of zero.
  assign write_hits_zero = (ZERO_REG != 0) && (bus.write_reg == '0);
  assign do_write        = bus.reg_write && !write_hits_zero;

  // Reset clears every location, so no read ever returns X. It also holds
  // off writes for as long as rst stays low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (do_write) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // Register 0 is also forced to zero on the read side. The result then
  // does not depend on how the storage for index 0 is built.
  assign bus.rd1 = ((ZERO_REG != 0) && (bus.read_reg_1 == '0)) ? '0 : regs[bus.read_reg_1];
  assign bus.rd2 = ((ZERO_REG != 0) && (bus.read_reg_2 == '0)) ? '0 : regs[bus.read_reg_2];

endmodule

// File: tb/tb_mips_register_file.sv
module tb_mips_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic        clk;
  logic        rst;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] wd;
  logic        we;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memories: one for the ZERO_REG=1 instance, one for ZERO_REG=0.
  logic [31:0] mem_z  [32];
  logic [31:0] mem_nz [32];

  mips_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_z ();
  mips_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nz ();

  assign bus_z.read_reg_1  = rr1;
  assign bus_z.read_reg_2  = rr2;
  assign bus_z.write_reg   = wr;
  assign bus_z.write_data  = wd;
  assign bus_z.reg_write   = we;
  assign bus_nz.read_reg_1 = rr1;
  assign bus_nz.read_reg_2 = rr2;
  assign bus_nz.write_reg  = wr;
  assign bus_nz.write_data = wd;
  assign bus_nz.reg_write  = we;

  mips_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

  mips_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_nz (
    .clk (clk),
    .rst (rst),
    .bus (bus_nz.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_z(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mem_z[a];
  endfunction

  function automatic logic [31:0] exp_nz(input logic [4:0] a);
    return mem_nz[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem_z[i]  = 32'h0;
      mem_nz[i] = 32'h0;
    end
  endtask

  // Rising edge: the model commits whatever the inputs ask for, then the
  // outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst && we) begin
      mem_nz[wr] = wd;
      mem_z[wr]  = wd;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wr = a;
    wd = d;
    tick();
    @(negedge clk);
    we = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    we  = 1'b0;
    wr  = '0;
    wd  = '0;
    rr1 = 5'd5;
    rr2 = 5'd31;
    model_clear();
    #12;
    n_checks++;
    if (bus_z.rd1 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rd1: got %h expected %h", bus_z.rd1, 32'h0);
    end
    n_checks++;
    if (bus_z.rd2 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rd2: got %h expected %h", bus_z.rd2, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_z.rd1 !== 32'h0 || bus_z.rd2 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_release: got %h/%h expected 0/0", bus_z.rd1, bus_z.rd2);
    end
  endtask

  task automatic test_write_read();
    rr2 = 5'd1;
    write_reg(5'd1, 32'hb17eb17e);
    n_checks++;
    if (bus_z.rd2 !== 32'hb17eb17e) begin
      n_errors++;
      $display("FAIL write_read: got %h expected %h", bus_z.rd2, 32'hb17eb17e);
    end
    // write_reg=1 with reg_write=0: the register must not change.
    wr = 5'd1;
    wd = 32'h12345678;
    we = 1'b0;
    tick();
    n_checks++;
    if (bus_z.rd2 !== 32'hb17eb17e) begin
      n_errors++;
      $display("FAIL write_disabled: got %h expected %h", bus_z.rd2, 32'hb17eb17e);
    end
  endtask

  task automatic test_zero_reg();
    rr1 = 5'd0;
    write_reg(5'd0, 32'hb19b00b5);
    n_checks++;
    if (bus_z.rd1 !== 32'h0) begin
      n_errors++;
      $display("FAIL zero_reg_hardwired: got %h expected %h", bus_z.rd1, 32'h0);
    end
    n_checks++;
    if (bus_nz.rd1 !== 32'hb19b00b5) begin
      n_errors++;
      $display("FAIL zero_reg_ordinary: got %h expected %h", bus_nz.rd1, 32'hb19b00b5);
    end
  endtask

  task automatic test_read_during_write();
    write_reg(5'd3, 32'hAAAA5555);
    rr1 = 5'd3;
    rr2 = 5'd3;
    we  = 1'b1;
    wr  = 5'd3;
    wd  = 32'h0F0F0F0F;
    #1;
    n_checks++;
    if (bus_z.rd1 !== 32'hAAAA5555 || bus_z.rd2 !== 32'hAAAA5555) begin
      n_errors++;
      $display("FAIL rdw_before_edge: got %h/%h expected %h", bus_z.rd1, bus_z.rd2, 32'hAAAA5555);
    end
    tick();
    n_checks++;
    if (bus_z.rd1 !== 32'h0F0F0F0F || bus_z.rd2 !== 32'h0F0F0F0F) begin
      n_errors++;
      $display("FAIL rdw_after_edge: got %h/%h expected %h", bus_z.rd1, bus_z.rd2, 32'h0F0F0F0F);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) begin
      write_reg(i[4:0], 32'h1000_0000 + i);
    end
    for (int i = 0; i < 32; i++) begin
      rr1 = i[4:0];
      rr2 = 5'(31 - i);
      #1;
      e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + (31 - i);
      n_checks++;
      if (bus_z.rd1 !== e1 || bus_z.rd2 !== e2) begin
        n_errors++;
        $display("FAIL sweep_pair_%0d: got %h/%h expected %h/%h", i, bus_z.rd1, bus_z.rd2, e1, e2);
      end
      n_checks++;
      if (bus_nz.rd1 !== exp_nz(rr1) || bus_nz.rd2 !== exp_nz(rr2)) begin
        n_errors++;
        $display("FAIL sweep_nz_pair_%0d: got %h/%h expected %h/%h", i, bus_nz.rd1, bus_nz.rd2,
                 exp_nz(rr1), exp_nz(rr2));
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rr1 = 5'd7;
    rr2 = 5'd31;
    we  = 1'b1;
    wr  = 5'd7;
    wd  = 32'hDEADBEEF;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (bus_z.rd1 !== 32'h0 || bus_z.rd2 !== 32'h0 || bus_nz.rd1 !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset_immediate: got %h/%h/%h expected 0", bus_z.rd1, bus_z.rd2, bus_nz.rd1);
    end
    tick();  // rst still low: the pending write must be lost
    n_checks++;
    if (bus_z.rd1 !== 32'h0 || bus_nz.rd1 !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset_write_blocked: got %h/%h expected 0", bus_z.rd1, bus_nz.rd1);
    end
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rr1 = i[4:0];
      rr2 = i[4:0];
      #1;
      n_checks++;
      if (bus_z.rd1 !== 32'h0 || bus_nz.rd2 !== 32'h0) begin
        n_errors++;
        $display("FAIL async_reset_clear_%0d: got %h/%h expected 0", i, bus_z.rd1, bus_nz.rd2);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rr1 = 5'($urandom_range(0, 31));
      rr2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      we  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wd  = $urandom;
      #1;
      n_checks++;
      if (bus_z.rd1 !== exp_z(rr1) || bus_z.rd2 !== exp_z(rr2)) begin
        n_errors++;
        $display("FAIL random_pre_%0d: got %h/%h expected %h/%h", n, bus_z.rd1, bus_z.rd2,
                 exp_z(rr1), exp_z(rr2));
      end
      tick();
      n_checks++;
      if (bus_z.rd1 !== exp_z(rr1) || bus_z.rd2 !== exp_z(rr2) ||
          bus_nz.rd1 !== exp_nz(rr1) || bus_nz.rd2 !== exp_nz(rr2)) begin
        n_errors++;
        $display("FAIL random_post_%0d: got %h/%h nz %h/%h expected %h/%h nz %h/%h", n,
                 bus_z.rd1, bus_z.rd2, bus_nz.rd1, bus_nz.rd2,
                 exp_z(rr1), exp_z(rr2), exp_nz(rr1), exp_nz(rr2));
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_read_during_write();
    test_sweep();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
